// File: rtl/svnet_pkg.sv
// Shared svnet definitions: gather state encoding and the lane-packing convention
// used by both the gather stage and the tree adder.
package svnet_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } svnet_gather_state_t;

   // Packed vectors put lane 0 in the LSBs; lane n starts at bit n*width.
   function automatic int svnet_lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/svnet_tree_gather.sv
// Gathers a stream of operand words into a COUNT-lane vector for the tree adder.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
module svnet_tree_gather
   import svnet_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int COUNT = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   output logic                         i_ready,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_last,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic [COUNT*WIDTH-1:0]       o_data,
   output logic [$clog2(COUNT+1)-1:0]   o_count,
   output svnet_gather_state_t          dbg_state
);

   localparam int CNT_W = $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   svnet_gather_state_t        state_q, state_d;
   logic [CNT_W-1:0]           idx_q, idx_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic [COUNT*WIDTH-1:0]     data_q, data_d;
   logic                       accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         idx_q   <= '0;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      data_d  = data_q;
      i_ready = (state_q == FILL) ? 1'b1 : o_ready;
      accept  = i_valid && i_ready;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               for (int l = 0; l < COUNT; l++) begin
                  if (idx_q == CNT_W'(l)) data_d[svnet_lane_lsb(l, WIDTH) +: WIDTH] = i_data;
               end
               if (idx_q == LAST_IDX || i_last) begin
                  state_d = FULL;
                  count_d = idx_q + ONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + ONE;
               end
            end
         end
         FULL: begin
            // Handoff clears the vector; a word arriving in the same cycle seeds lane 0.
            if (o_ready) begin
               state_d = FILL;
               idx_d   = '0;
               count_d = '0;
               data_d  = '0;
               if (accept) begin
                  data_d[WIDTH-1:0] = i_data;
                  if (LAST_IDX == '0 || i_last) begin
                     state_d = FULL;
                     count_d = ONE;
                  end else begin
                     idx_d = ONE;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   assign o_valid   = !rst && (state_q == FULL);
   assign o_data    = rst ? '0 : data_q;
   assign o_count   = rst ? '0 : count_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_svnet_tree_gather.sv
// Bench for svnet_tree_gather: a COUNT=4 and a COUNT=1 instance share one stimulus
// stream; a vector-level model fills expected queues that a negedge monitor drains.
module tb_svnet_tree_gather;
   import svnet_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_valid = 1'b0;
   logic [7:0] i_data = '0;
   logic       i_last = 1'b0;
   logic       o_ready = 1'b0;

   logic        i_ready4, o_valid4, i_ready1, o_valid1;
   logic [31:0] o_data4;
   logic [2:0]  o_count4;
   logic [7:0]  o_data1;
   logic [0:0]  o_count1;
   svnet_gather_state_t dbg4, dbg1;

   int checks = 0;
   int errors = 0;

   // Model state per instance (0: COUNT=4, 1: COUNT=1)
   int          part_n[2];
   logic [31:0] part_v[2];
   logic        busy[2];
   int          vec_cnt[2];
   logic [39:0] exp_q4[$];
   logic [39:0] exp_q1[$];

   svnet_tree_gather #(.WIDTH(8), .COUNT(4)) dut4 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready4), .i_data(i_data),
      .i_last(i_last), .o_valid(o_valid4), .o_ready(o_ready), .o_data(o_data4),
      .o_count(o_count4), .dbg_state(dbg4)
   );

   svnet_tree_gather #(.WIDTH(8), .COUNT(1)) dut1 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready1), .i_data(i_data),
      .i_last(i_last), .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1),
      .o_count(o_count1), .dbg_state(dbg1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int k, input logic [47:0] act, input logic [47:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, expv, $time);
      end
   endtask

   // Vector-level reference: words accumulate into lanes until COUNT or i_last,
   // and at most one finished vector waits for the consumer.
   task automatic model(input int k, input int cnt);
      logic acc;
      if (rst) begin
         part_n[k] = 0;
         part_v[k] = '0;
         busy[k]   = 1'b0;
         if (k == 0) exp_q4.delete(); else exp_q1.delete();
         return;
      end
      acc = i_valid && (!busy[k] || o_ready);
      if (busy[k] && o_ready) busy[k] = 1'b0;
      if (acc) begin
         part_v[k] = part_v[k] | (32'(i_data) << (8 * part_n[k]));
         part_n[k] = part_n[k] + 1;
         if (part_n[k] == cnt || i_last) begin
            if (k == 0) exp_q4.push_back({8'(part_n[k]), part_v[k]});
            else        exp_q1.push_back({8'(part_n[k]), part_v[k]});
            busy[k]   = 1'b1;
            part_n[k] = 0;
            part_v[k] = '0;
         end
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic l, input logic ordy, input logic r);
      i_valid = v;
      i_data  = d;
      i_last  = l;
      o_ready = ordy;
      rst     = r;
      @(posedge clk);
      model(0, 4);
      model(1, 1);
      #2;
   endtask

   task automatic mon(input int k, input logic ov, input logic ir, input logic [39:0] act);
      logic [39:0] front;
      if (rst) begin
         chk("rst_outputs", k, 48'({ov, act}), 48'd0);
      end else begin
         chk("o_valid", k, 48'(ov), 48'(busy[k]));
         chk("i_ready", k, 48'(ir), 48'(!busy[k] || o_ready));
         if (ov) begin
            if ((k == 0 && exp_q4.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
               checks++;
               errors++;
               $display("FAIL spurious_vector dut%0d: got %h expected none at %0t", k, act, $time);
            end else begin
               front = (k == 0) ? exp_q4[0] : exp_q1[0];
               chk("vector", k, 48'(act), 48'(front));
               if (o_ready) begin
                  if (k == 0) void'(exp_q4.pop_front()); else void'(exp_q1.pop_front());
                  vec_cnt[k]++;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, o_valid4, i_ready4, {5'd0, o_count4, o_data4});
      mon(1, o_valid1, i_ready1, {7'd0, o_count1, 24'd0, o_data1});
   end

   initial begin
      int b0, b1;
      for (int k = 0; k < 2; k++) begin
         part_n[k] = 0; part_v[k] = '0; busy[k] = 1'b0; vec_cnt[k] = 0;
      end
      repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Full vector, then flush with i_last
      step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Backpressure with 0x55 waiting, then zero-bubble handoff
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
      repeat (5) step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Reset mid-vector
      step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Streaming: 12 words
      b0 = vec_cnt[0]; b1 = vec_cnt[1];
      for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("stream_vectors", 0, 48'(vec_cnt[0] - b0), 48'd3);
      chk("stream_vectors", 1, 48'(vec_cnt[1] - b1), 48'd12);

      // Eight consecutive words
      b1 = vec_cnt[1];
      for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("single_lane_vectors", 1, 48'(vec_cnt[1] - b1), 48'd8);

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      end
      repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("queue_drained", 0, 48'(exp_q4.size()), 48'd0);
      chk("queue_drained", 1, 48'(exp_q1.size()), 48'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/svnet_tree_gather.md
SVNET_TREE_GATHER -- requirements
Module: svnet_tree_gather

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 1, SHALL set the bit width of one operand word.
REQ-003 Parameter COUNT, default 1, SHALL set the number of lanes per output vector; legal range COUNT >= 1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 i_valid  input  1  SHALL indicate that i_data and i_last are presented.
REQ-007 i_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-008 i_data  input  WIDTH  SHALL carry one signed operand word.
REQ-009 i_last  input  1  SHALL mark the final word of a partial vector (flush).
REQ-010 o_valid  output  1  SHALL indicate that a complete vector is presented.
REQ-011 o_ready  input  1  SHALL indicate that the downstream tree adder takes the vector.
REQ-012 o_data  output  COUNT x WIDTH (packed, lane 0 in the LSBs)  SHALL carry the gathered vector.
REQ-013 o_count  output  $clog2(COUNT+1)  SHALL report the number of lanes written, range 1..COUNT.

Function
REQ-014 A word SHALL be accepted only when i_valid && i_ready are both high in the same cycle.
REQ-015 Accepted words SHALL be written to lanes in order: lane 0 first, then ascending; a lane index counter idx SHALL advance by 1 per accepted word.
REQ-016 The state machine SHALL have two states. FILL: o_valid=0, i_ready=1. FULL: o_valid=1, i_ready=o_ready.
REQ-017 FILL->FULL SHALL occur on acceptance of a word when idx==COUNT-1 or i_last==1; o_valid SHALL assert the cycle after that acceptance (latency 1).
REQ-018 On entry to FULL, unwritten lanes SHALL read 0, so downstream summation is unaffected.
REQ-019 On entry to FULL, o_count SHALL equal idx+1 at the completing acceptance.
REQ-020 In FULL with o_ready=0, o_data, o_count and o_valid SHALL hold stable and no word SHALL be accepted.
REQ-021 In FULL with o_ready=1 and no accepted word, the vector SHALL be cleared to 0, idx SHALL become 0, and the state SHALL go to FILL.
REQ-022 In FULL with o_ready=1 and a word accepted in the same cycle, the new vector SHALL contain only that word in lane 0 with idx=1, state FILL (or FULL again if COUNT==1 or i_last==1); this SHALL give zero-bubble throughput of one word per cycle.
REQ-023 For COUNT==1, every accepted word SHALL complete a vector with o_count=1.
REQ-024 In FILL with idx<COUNT-1, i_last==0 and i_valid==0, state and lanes SHALL hold.

Reset
REQ-025 While rst is high: o_valid=0, o_data=0, o_count=0, idx=0, state=FILL.
REQ-026 i_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 A reset mid-vector SHALL discard all partial lanes; no residue SHALL appear in later vectors.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-029 The state enum typedef (FILL/FULL) SHALL live in the shared svnet package as svnet_gather_state_t.
REQ-030 The vector-packing convention (lane 0 in the LSBs) SHALL live in the shared svnet package, so that svnet_tree_gather and svnet_tree_add agree.
REQ-031 The block SHALL be a single module with no sub-module; o_data SHALL connect directly to the i_data of svnet_tree_add.

Verification (WIDTH=8, COUNT=4 unless stated)
REQ-032 Full vector: push 0x11, 0x22, 0x33, 0x44 back-to-back with o_ready=1 -> o_valid for one cycle, the cycle after the 0x44 accept, with lanes [0..3] = 0x11/0x22/0x33/0x44 and o_count=4.
REQ-033 Flush: push 0x11, 0x22, then 0x33 with i_last=1 -> lanes = 0x11/0x22/0x33/0x00 and o_count=3.
REQ-034 Backpressure: complete a vector, then hold o_ready=0 for 5 cycles -> o_valid, o_data and o_count stable, i_ready=0, no words lost; raise o_ready with 0x55 presented -> handoff, and 0x55 lands in lane 0 of the next vector.
REQ-035 Reset mid-vector: push 0x01, 0x02, pulse rst, then push 0xA0..0xA3 -> vector = 0xA0/0xA1/0xA2/0xA3, o_count=4, and all outputs are 0 during rst.
REQ-036 Streaming: 12 consecutive words with o_ready=1 -> exactly 3 vectors, o_valid every 4th cycle, i_ready never drops.
REQ-037 COUNT=1: push 8 consecutive words -> 8 vectors, each one cycle after its accept, each with o_count=1.
